// File: rtl/three_input_gate_sweep_v_pkg.sv
// Shared definitions for the three-input gate sweep sequencer and its golden lookup.
package three_input_gate_sweep_v_pkg;

    // Gate select codes as seen on the gate's i_code input.
    localparam logic [1:0] CODE_XOR  = 2'b00;
    localparam logic [1:0] CODE_NAND = 2'b01;
    localparam logic [1:0] CODE_NOR  = 2'b10;
    localparam logic [1:0] CODE_XNOR = 2'b11;

    // Expected truth table; bit index = {code, a, b, c}.
    localparam logic [31:0] GOLDEN_TT = 32'h69017F96;

    localparam int unsigned NUM_VECTORS = 32;
    localparam logic [4:0]  LAST_IDX    = 5'd31;
    localparam logic [5:0]  MAX_ERRS    = 6'd32;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StSettle = 2'b01,
        StSample = 2'b10,
        StDone   = 2'b11
    } sweep_state_e;

endpackage

// File: rtl/three_input_gate_sweep_v_if.sv
// Signal bundle between the sweep sequencer and its host plus gate-under-test.
interface three_input_gate_sweep_v_if;

    logic        i_start;
    logic        o_a;
    logic        o_b;
    logic        o_c;
    logic [1:0]  o_code;
    logic        i_f;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_result;
    logic [5:0]  o_err_cnt;
    logic        o_pass;

    // Sequencer side.
    modport master (
        input  i_start,
        input  i_f,
        output o_a,
        output o_b,
        output o_c,
        output o_code,
        output o_busy,
        output o_done,
        output o_result,
        output o_err_cnt,
        output o_pass
    );

    // Host / gate side.
    modport slave (
        output i_start,
        output i_f,
        input  o_a,
        input  o_b,
        input  o_c,
        input  o_code,
        input  o_busy,
        input  o_done,
        input  o_result,
        input  o_err_cnt,
        input  o_pass
    );

endinterface

// File: rtl/three_input_gate_ref_v.sv
// Combinational golden lookup: vector index {code,a,b,c} -> expected gate output.
module three_input_gate_ref_v
    import three_input_gate_sweep_v_pkg::*;
(
    input  logic [4:0] idx,
    output logic       expected
);

    assign expected = GOLDEN_TT[idx];

endmodule

// File: rtl/three_input_gate_sweep_v.sv
// Exhaustive self-test sequencer for three_input_gate_v: drives all 32 vectors,
// captures the truth table and counts mismatches against the golden model.
module three_input_gate_sweep_v
    import three_input_gate_sweep_v_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    three_input_gate_sweep_v_if.master      bus
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
    localparam bit         NO_SETTLE   = (SETTLE_CYCLES == 0);

    sweep_state_e state_q, state_d;
    logic [4:0]   idx_q, idx_d;
    logic [3:0]   settle_q, settle_d;
    logic [4:0]   vec_q, vec_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [31:0]  result_q, result_d;
    logic [5:0]   err_q, err_d;
    logic         pass_q, pass_d;
    logic         expected;

    three_input_gate_ref_v u_ref (
        .idx      (idx_q),
        .expected (expected)
    );

    // Next-state and registered-output logic for the sweep FSM.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        result_d = result_q;
        err_d    = err_q;
        pass_d   = pass_q;
        done_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.i_start) begin
                    result_d = '0;
                    err_d    = '0;
                    idx_d    = '0;
                    settle_d = SETTLE_LOAD;
                    state_d  = NO_SETTLE ? StSample : StSettle;
                end
            end
            StSettle: begin
                settle_d = settle_q - 4'd1;
                if (settle_d == 4'd0) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                result_d[idx_q] = bus.i_f;
                // Saturate defensively; 32 vectors cannot exceed MAX_ERRS anyway.
                if ((bus.i_f != expected) && (err_q != MAX_ERRS)) begin
                    err_d = err_q + 6'd1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = StDone;
                end else begin
                    idx_d    = idx_q + 5'd1;
                    settle_d = SETTLE_LOAD;
                    state_d  = NO_SETTLE ? StSample : StSettle;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                pass_d  = (err_q == 6'd0);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Gate inputs track the index only while busy; parked at zero otherwise.
        busy_d = (state_d == StSettle) || (state_d == StSample);
        vec_d  = busy_d ? idx_d : 5'd0;
    end

    // State and output registers; reset clears every output immediately.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            settle_q <= '0;
            vec_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            err_q    <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            vec_q    <= vec_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            err_q    <= err_d;
            pass_q   <= pass_d;
        end
    end

    assign bus.o_code    = vec_q[4:3];
    assign bus.o_a       = vec_q[2];
    assign bus.o_b       = vec_q[1];
    assign bus.o_c       = vec_q[0];
    assign bus.o_busy    = busy_q;
    assign bus.o_done    = done_q;
    assign bus.o_result  = result_q;
    assign bus.o_err_cnt = err_q;
    assign bus.o_pass    = pass_q;

endmodule
